led_pwm_ctrl: RTL and testbench
===============================

// Module: led_pwm_ctrl
// PURPOSE
//  MMIO-programmable brightness/blink stage placed directly downstream of the 4-bit LED
//  register device. Takes its led[3:0] word, where 0 = lit and board LEDs are active-low,
//  and drives the physical pins. Four modes: direct, PWM-dimmed, blinking, breathing.
//  Shares the bridge's WE/Addr/Din/Dout bus style with the other devices.
// PARAMETERS
//  PRESCALE   16  clk cycles per PWM tick (>=1)
//  PWM_BITS   8   PWM counter/duty width; frame = 2**PWM_BITS ticks
//  BLINK_BITS 16  width of blink half-period register (in PWM frames)
// PORTS
//  clk      in   1         system clock
//  rst      in   1         asynchronous reset, active-high
//  WE       in   1         register write strobe (one cycle)
//  Addr     in   2         register select: 0 CTRL, 1 DUTY, 2 PERIOD, 3 STATUS (read-only)
//  Din      in   32        write data
//  Dout     out  32        read data, combinational mux on Addr, zero-extended
//  led_in   in   4         LED register word (bit=0 requests lit)
//  led_out  out  4         physical pins, active-low (0 = lit)
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): mode=0, duty=all-ones, period=1,
//   all counters 0, phase=1, level=0, dir=UP, led_out=4'b1111.
//  CTRL[1:0] mode: 0 DIRECT, 1 PWM, 2 BLINK, 3 BREATHE. A CTRL write clears the prescaler,
//   pwm_cnt, blink_cnt and level; sets phase=1 and dir=UP; starts a new frame next cycle.
//  DUTY[PWM_BITS-1:0] is written into a shadow register and copied to duty_act only on frame_end.
//   A write in the same cycle as frame_end is copied at that frame_end.
//  PERIOD[BLINK_BITS-1:0]: a write of 0 is stored as 1. It takes effect on the next phase toggle.
//  Prescaler counts 0..PRESCALE-1. tick = (presc==PRESCALE-1).
//   pwm_cnt increments on tick and wraps. frame_end = tick && pwm_cnt==all-ones.
//  gate per mode, computed each cycle:
//   DIRECT : 1
//   PWM    : pwm_cnt < duty_act. duty 0 => never lit; all-ones => lit 255/256 of frame.
//   BLINK  : phase. On frame_end blink_cnt++. When blink_cnt+1==period, blink_cnt=0 and phase toggles.
//   BREATHE: pwm_cnt < level. On frame_end:
//            UP   : level++ ; when level+1 >= duty_act, set level=duty_act and dir=DOWN.
//            DOWN : level-- ; when level-1 == 0, set level=0 and dir=UP.
//            If duty_act==0, level stays 0.
//  led_out <= ~(~led_in & {4{gate}}), registered: 1-cycle latency from led_in/gate to pin.
//   Bits whose led_in is 1 are never lit.
//  STATUS read: {27'd0, dir, phase, mode_bits, frame_toggle}. frame_toggle inverts every frame_end.
//  Reads of CTRL/DUTY/PERIOD return the stored value (DUTY returns the shadow).
//  Unused write bits are ignored. WE with Addr=3 has no effect.
// TESTING
//  (Bench uses PRESCALE=1, PWM_BITS=4.)
//  1. Reset: assert rst mid-frame in PWM mode -> led_out=4'b1111 in the same cycle;
//     Dout@0=0, Dout@1=0xF, Dout@2=1.
//  2. DIRECT mode, led_in=4'b1010 -> led_out=4'b1010 one cycle later; led_in=4'b0000 -> 4'b0000 next cycle.
//  3. PWM mode, DUTY=5, led_in=4'b1110 -> bit0 low for exactly 5 of every 16 cycles.
//     DUTY=0 gives never low; bits 3:1 stay 1 throughout.
//  4. DUTY write of 3 mid-frame (old duty 10) -> current frame still shows 10 lit cycles;
//     the next frame shows 3. A write landing on the frame_end cycle -> the next frame already uses 3.
//  5. BLINK mode, PERIOD=2 -> bit0 lit for 32 cycles then dark for 32, repeating.
//     Writing PERIOD=0 reads back 1 and gives 16/16.
//  6. BREATHE mode, DUTY=3 -> per-frame lit counts 0,1,2,3,2,1,0,1,...
//     A CTRL rewrite mid-ramp restarts at level 0, dir UP.

Source files
------------

// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_ctrl
//  Description : Register-programmable brightness / blink stage that sits
//                between the 4-bit LED register device and the active-low
//                board pins. Modes: direct, PWM dimming, blinking, breathing.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_ctrl #(
  parameter int PRESCALE   = 16,  // clk cycles per PWM tick (>= 1)
  parameter int PWM_BITS   = 8,   // PWM counter / duty width
  parameter int BLINK_BITS = 16   // blink half-period width, in PWM frames
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [1:0]  Addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [3:0]  led_in,
  output logic [3:0]  led_out
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX = c_PRESC_W'(PRESCALE - 1);
  localparam logic [c_PRESC_W-1:0]  c_PRESC_ONE = c_PRESC_W'(1);
  localparam logic [PWM_BITS-1:0]   c_PWM_MAX   = '1;
  localparam logic [PWM_BITS-1:0]   c_PWM_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS:0]     c_LVL_ONE   = (PWM_BITS + 1)'(1);
  localparam logic [BLINK_BITS-1:0] c_BLINK_ONE = BLINK_BITS'(1);

  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_DUTY   = 2'd1;
  localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS = 2'd3;

  localparam logic [1:0] c_MODE_DIRECT  = 2'd0;
  localparam logic [1:0] c_MODE_PWM     = 2'd1;
  localparam logic [1:0] c_MODE_BLINK   = 2'd2;
  localparam logic [1:0] c_MODE_BREATHE = 2'd3;

  // Breathing ramp direction state machine encoding
  localparam logic [0:0] c_DIR_UP   = 1'b0;
  localparam logic [0:0] c_DIR_DOWN = 1'b1;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [1:0]            r_mode;
  logic [PWM_BITS-1:0]   r_duty_sh;
  logic [PWM_BITS-1:0]   r_duty_act;
  logic [BLINK_BITS-1:0] r_period;
  logic [BLINK_BITS-1:0] r_period_act;
  logic [c_PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [BLINK_BITS-1:0] r_blink_cnt;
  logic                  r_phase;
  logic [PWM_BITS-1:0]   r_level;
  logic [0:0]            r_dir;
  logic                  r_frame_toggle;
  logic [3:0]            r_led_out;

  logic                  w_wr_ctrl;
  logic                  w_wr_duty;
  logic                  w_wr_period;
  logic [PWM_BITS-1:0]   w_din_duty;
  logic [BLINK_BITS-1:0] w_din_period;
  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_blink_step;
  logic                  w_blink_wrap;
  logic                  w_breathe_step;
  logic [PWM_BITS:0]     w_level_inc;
  logic [0:0]            w_dir_next;
  logic [PWM_BITS-1:0]   w_level_next;
  logic                  w_gate;
  logic                  w_unused_din;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_wr_ctrl    = WE && (Addr == c_ADDR_CTRL);
  assign w_wr_duty    = WE && (Addr == c_ADDR_DUTY);
  assign w_wr_period  = WE && (Addr == c_ADDR_PERIOD);
  assign w_din_duty   = Din[PWM_BITS-1:0];
  assign w_din_period = Din[BLINK_BITS-1:0];

  // Upper write-data bits have no destination; fold them into a sink.
  assign w_unused_din = &{1'b0, Din};

  // --------------------------------------------------------------------------
  // Timebase
  // --------------------------------------------------------------------------
  assign w_tick      = (r_presc == c_PRESC_MAX);
  assign w_frame_end = w_tick && (r_pwm_cnt == c_PWM_MAX);

  // Prescaler: divides clk down to the PWM tick rate; CTRL write restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_wr_ctrl || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_PRESC_ONE;
    end
  end

  // PWM position counter: advances once per tick and wraps every frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else if (w_wr_ctrl) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
    end
  end

  // Frame toggle: software-visible heartbeat that flips on every frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_toggle <= 1'b0;
    end else if (w_frame_end) begin
      r_frame_toggle <= ~r_frame_toggle;
    end
  end

  // --------------------------------------------------------------------------
  // Programming registers
  // --------------------------------------------------------------------------
  // Mode register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= c_MODE_DIRECT;
    end else if (w_wr_ctrl) begin
      r_mode <= Din[1:0];
    end
  end

  // Duty shadow and active copy; the active copy only changes at a frame
  // boundary so a frame is never drawn with two different duties. A write
  // landing on the boundary cycle is forwarded straight into the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_sh  <= '1;
      r_duty_act <= '1;
    end else begin
      if (w_wr_duty) begin
        r_duty_sh <= w_din_duty;
      end
      if (w_frame_end) begin
        r_duty_act <= w_wr_duty ? w_din_duty : r_duty_sh;
      end
    end
  end

  // Blink half-period register; zero would never terminate a phase, so it
  // is stored as one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= c_BLINK_ONE;
    end else if (w_wr_period) begin
      r_period <= (w_din_period == '0) ? c_BLINK_ONE : w_din_period;
    end
  end

  // --------------------------------------------------------------------------
  // Blink engine
  // --------------------------------------------------------------------------
  assign w_blink_step = w_frame_end && (r_mode == c_MODE_BLINK);
  assign w_blink_wrap = ((r_blink_cnt + c_BLINK_ONE) == r_period_act);

  // Blink counter and phase; the active period is reloaded at each phase
  // toggle and when a CTRL write restarts the pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt  <= '0;
      r_phase      <= 1'b1;
      r_period_act <= c_BLINK_ONE;
    end else if (w_wr_ctrl) begin
      r_blink_cnt  <= '0;
      r_phase      <= 1'b1;
      r_period_act <= r_period;
    end else if (w_blink_step) begin
      if (w_blink_wrap) begin
        r_blink_cnt  <= '0;
        r_phase      <= ~r_phase;
        r_period_act <= r_period;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Breathing engine: ramp direction FSM plus brightness level
  // --------------------------------------------------------------------------
  assign w_breathe_step = w_frame_end && (r_mode == c_MODE_BREATHE);
  assign w_level_inc    = {1'b0, r_level} + c_LVL_ONE;

  // Direction state register; CTRL write restarts the ramp going up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir <= c_DIR_UP;
    end else if (w_wr_ctrl) begin
      r_dir <= c_DIR_UP;
    end else begin
      r_dir <= w_dir_next;
    end
  end

  // Direction next-state: turn around at the duty ceiling and at zero.
  always_comb begin
    w_dir_next = r_dir;
    if (w_breathe_step && (r_duty_act != '0)) begin
      case (r_dir)
        c_DIR_UP: begin
          if (w_level_inc >= {1'b0, r_duty_act}) begin
            w_dir_next = c_DIR_DOWN;
          end
        end
        c_DIR_DOWN: begin
          if (r_level <= c_PWM_ONE) begin
            w_dir_next = c_DIR_UP;
          end
        end
        default: w_dir_next = c_DIR_UP;
      endcase
    end
  end

  // Level output logic: one step per frame, clamped to [0, duty_act].
  always_comb begin
    w_level_next = r_level;
    if (w_breathe_step) begin
      if (r_duty_act == '0) begin
        w_level_next = '0;
      end else begin
        case (r_dir)
          c_DIR_UP: begin
            if (w_level_inc >= {1'b0, r_duty_act}) begin
              w_level_next = r_duty_act;
            end else begin
              w_level_next = r_level + c_PWM_ONE;
            end
          end
          c_DIR_DOWN: begin
            if (r_level <= c_PWM_ONE) begin
              w_level_next = '0;
            end else begin
              w_level_next = r_level - c_PWM_ONE;
            end
          end
          default: w_level_next = '0;
        endcase
      end
    end
  end

  // Level register; CTRL write restarts from dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_wr_ctrl) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_next;
    end
  end

  // --------------------------------------------------------------------------
  // Output gate and pin register
  // --------------------------------------------------------------------------
  // Per-mode enable: when low, every pin is forced dark.
  always_comb begin
    w_gate = 1'b1;
    case (r_mode)
      c_MODE_DIRECT:  w_gate = 1'b1;
      c_MODE_PWM:     w_gate = (r_pwm_cnt < r_duty_act);
      c_MODE_BLINK:   w_gate = r_phase;
      c_MODE_BREATHE: w_gate = (r_pwm_cnt < r_level);
      default:        w_gate = 1'b1;
    endcase
  end

  // Pin register: a pin is lit only if requested (led_in=0) and gated on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_out <= 4'b1111;
    end else begin
      r_led_out <= ~(~led_in & {4{w_gate}});
    end
  end

  assign led_out = r_led_out;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  // Combinational readback; DUTY returns the shadow, not the active copy.
  always_comb begin
    Dout = '0;
    case (Addr)
      c_ADDR_CTRL:   Dout = {30'd0, r_mode};
      c_ADDR_DUTY:   Dout = 32'(r_duty_sh);
      c_ADDR_PERIOD: Dout = 32'(r_period);
      c_ADDR_STATUS: Dout = {27'd0, r_dir, r_phase, r_mode, r_frame_toggle};
      default:       Dout = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pwm_ctrl
//  Description : Self-checking bench for led_pwm_ctrl (PRESCALE=1,
//                PWM_BITS=4). Expected pin patterns come from per-frame lit
//                counts derived from the mode rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_ctrl;

  localparam int c_FRAME = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        WE;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [3:0]  led_in;
  logic [3:0]  led_out;

  int checks   = 0;
  int failures = 0;
  int exp_lit[0:63];

  led_pwm_ctrl #(
    .PRESCALE   (1),
    .PWM_BITS   (4),
    .BLINK_BITS (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .WE      (WE),
    .Addr    (Addr),
    .Din     (Din),
    .Dout    (Dout),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    WE = 1'b1; Addr = a; Din = d;
    @(negedge clk);
    WE = 1'b0; Din = '0;
  endtask

  // Write DUTY and wait long enough that a frame end has copied it.
  task automatic settle_duty(input logic [31:0] d);
    wr_reg(2'd1, d);
    repeat (c_FRAME + 1) @(negedge clk);
  endtask

  // CTRL write: after return the bench sits in cycle 0 of a fresh frame.
  task automatic start_mode(input logic [31:0] m);
    wr_reg(2'd0, m);
  endtask

  // Model: lit cycles per frame for the breathing triangle wave.
  function automatic int breathe_level(input int d, input int f);
    int t;
    if (d == 0) return 0;
    t = f % (2 * d);
    return (t <= d) ? t : (2 * d - t);
  endfunction

  // Walk nframes frames comparing every pin cycle against exp_lit[]; an
  // optional register write lands in cycle wr_idx+1.
  task automatic check_frames(input string name, input int nframes, input int wr_idx,
                              input logic [1:0] wa, input logic [31:0] wd);
    logic [3:0] exp;
    int f, k;
    for (int i = 0; i < nframes * c_FRAME; i++) begin
      @(posedge clk); #1;
      f = i / c_FRAME;
      k = i % c_FRAME;
      exp = (k < exp_lit[f]) ? led_in : 4'b1111;
      checks++;
      if (led_out !== exp) begin
        failures++;
        $display("FAIL %s frame=%0d cycle=%0d led_out=%b expected=%b", name, f, k, led_out, exp);
      end
      if (i == wr_idx) begin
        WE = 1'b1; Addr = wa; Din = wd;
      end else if (i == wr_idx + 1) begin
        WE = 1'b0; Din = '0;
      end
    end
    WE = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    Addr = 2'd3;
    repeat (15) @(negedge clk); #1;
    checks++;
    if (Dout !== 32'h8) begin
      failures++; $display("FAIL status_after_reset got=%h exp=%h", Dout, 32'h8);
    end
    @(negedge clk); #1;
    checks++;
    if (Dout !== 32'h9) begin
      failures++; $display("FAIL status_frame_toggle got=%h exp=%h", Dout, 32'h9);
    end
    // Mid-frame async reset in PWM mode
    settle_duty(32'hF);
    led_in = 4'b0000;
    start_mode(32'd1);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (led_out !== 4'b0000) begin
      failures++; $display("FAIL pwm_before_reset got=%b exp=%b", led_out, 4'b0000);
    end
    rst = 1'b1; #1;
    checks++;
    if (led_out !== 4'b1111) begin
      failures++; $display("FAIL reset_led_out got=%b exp=%b", led_out, 4'b1111);
    end
    Addr = 2'd0; #1;
    checks++;
    if (Dout !== 32'h0) begin
      failures++; $display("FAIL reset_ctrl got=%h exp=%h", Dout, 32'h0);
    end
    Addr = 2'd1; #1;
    checks++;
    if (Dout !== 32'hF) begin
      failures++; $display("FAIL reset_duty got=%h exp=%h", Dout, 32'hF);
    end
    Addr = 2'd2; #1;
    checks++;
    if (Dout !== 32'h1) begin
      failures++; $display("FAIL reset_period got=%h exp=%h", Dout, 32'h1);
    end
    Addr = 2'd3; #1;
    checks++;
    if (Dout !== 32'h8) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", Dout, 32'h8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_direct;
    led_in = 4'b1111;
    start_mode(32'd0);
    @(posedge clk); #1;
    checks++;
    if (led_out !== 4'b1111) begin
      failures++; $display("FAIL direct_idle got=%b exp=%b", led_out, 4'b1111);
    end
    @(negedge clk);
    led_in = 4'b1010; #1;
    checks++;
    if (led_out !== 4'b1111) begin
      failures++; $display("FAIL direct_latency got=%b exp=%b", led_out, 4'b1111);
    end
    @(posedge clk); #1;
    checks++;
    if (led_out !== 4'b1010) begin
      failures++; $display("FAIL direct_1010 got=%b exp=%b", led_out, 4'b1010);
    end
    @(negedge clk);
    led_in = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (led_out !== 4'b0000) begin
      failures++; $display("FAIL direct_0000 got=%b exp=%b", led_out, 4'b0000);
    end
  endtask

  task automatic test_registers;
    wr_reg(2'd1, 32'hFFFF_FFF5);
    Addr = 2'd1; #1;
    checks++;
    if (Dout !== 32'h5) begin
      failures++; $display("FAIL duty_readback got=%h exp=%h", Dout, 32'h5);
    end
    wr_reg(2'd2, 32'h0003_0002);
    Addr = 2'd2; #1;
    checks++;
    if (Dout !== 32'h2) begin
      failures++; $display("FAIL period_readback got=%h exp=%h", Dout, 32'h2);
    end
    wr_reg(2'd0, 32'hFFFF_FFFE);
    wr_reg(2'd3, 32'hFFFF_FFFF);
    Addr = 2'd0; #1;
    checks++;
    if (Dout !== 32'h2) begin
      failures++; $display("FAIL ctrl_readback got=%h exp=%h", Dout, 32'h2);
    end
    Addr = 2'd1; #1;
    checks++;
    if (Dout !== 32'h5) begin
      failures++; $display("FAIL status_write_duty got=%h exp=%h", Dout, 32'h5);
    end
    Addr = 2'd2; #1;
    checks++;
    if (Dout !== 32'h2) begin
      failures++; $display("FAIL status_write_period got=%h exp=%h", Dout, 32'h2);
    end
    Addr = 2'd3; #1;
    checks++;
    if (Dout[4:1] !== 4'b0110) begin
      failures++; $display("FAIL status_mode got=%b exp=%b", Dout[4:1], 4'b0110);
    end
  endtask

  task automatic test_pwm;
    led_in = 4'b1110;
    settle_duty(32'd5);
    start_mode(32'd1);
    for (int f = 0; f < 3; f++) exp_lit[f] = 5;
    check_frames("pwm_duty5", 3, -1, 2'd0, 32'd0);
    settle_duty(32'd0);
    start_mode(32'd1);
    for (int f = 0; f < 2; f++) exp_lit[f] = 0;
    check_frames("pwm_duty0", 2, -1, 2'd0, 32'd0);
    settle_duty(32'd15);
    start_mode(32'd1);
    for (int f = 0; f < 2; f++) exp_lit[f] = 15;
    check_frames("pwm_duty15", 2, -1, 2'd0, 32'd0);
  endtask

  task automatic test_duty_update;
    led_in = 4'b0110;
    settle_duty(32'd10);
    start_mode(32'd1);
    exp_lit[0] = 10; exp_lit[1] = 3;
    check_frames("duty_midframe", 2, 4, 2'd1, 32'd3);
    settle_duty(32'd10);
    start_mode(32'd1);
    exp_lit[0] = 10; exp_lit[1] = 3;
    check_frames("duty_on_frame_end", 2, 14, 2'd1, 32'd3);
    settle_duty(32'd10);
    start_mode(32'd1);
    exp_lit[0] = 10; exp_lit[1] = 10; exp_lit[2] = 3;
    check_frames("duty_after_frame_end", 3, 15, 2'd1, 32'd3);
  endtask

  task automatic test_blink;
    led_in = 4'b1110;
    wr_reg(2'd2, 32'd2);
    start_mode(32'd2);
    for (int f = 0; f < 6; f++) exp_lit[f] = ((f / 2) % 2 == 0) ? c_FRAME : 0;
    check_frames("blink_period2", 6, -1, 2'd0, 32'd0);
    wr_reg(2'd2, 32'd0);
    Addr = 2'd2; #1;
    checks++;
    if (Dout !== 32'h1) begin
      failures++; $display("FAIL period_zero_readback got=%h exp=%h", Dout, 32'h1);
    end
    start_mode(32'd2);
    for (int f = 0; f < 4; f++) exp_lit[f] = (f % 2 == 0) ? c_FRAME : 0;
    check_frames("blink_period1", 4, -1, 2'd0, 32'd0);
  endtask

  task automatic test_breathe;
    led_in = 4'b1100;
    settle_duty(32'd3);
    start_mode(32'd3);
    for (int f = 0; f < 8; f++) exp_lit[f] = breathe_level(3, f);
    check_frames("breathe_duty3", 8, -1, 2'd0, 32'd0);
    // Now in frame 8 (level 2, still ramping up)
    Addr = 2'd3; #1;
    checks++;
    if (Dout[4:1] !== 4'b0111) begin
      failures++; $display("FAIL breathe_status_up got=%b exp=%b", Dout[4:1], 4'b0111);
    end
    repeat (c_FRAME) @(posedge clk); #1;
    checks++;
    if (Dout[4:1] !== 4'b1111) begin
      failures++; $display("FAIL breathe_status_down got=%b exp=%b", Dout[4:1], 4'b1111);
    end
    // Mid-ramp restart
    start_mode(32'd3);
    Addr = 2'd3; #1;
    checks++;
    if (Dout[4] !== 1'b0) begin
      failures++; $display("FAIL breathe_restart_dir got=%b exp=%b", Dout[4], 1'b0);
    end
    for (int f = 0; f < 6; f++) exp_lit[f] = breathe_level(3, f);
    check_frames("breathe_restart", 6, -1, 2'd0, 32'd0);
  endtask

  task automatic test_random;
    int mode, d, p;
    for (int it = 0; it < 6; it++) begin
      mode   = $urandom_range(1, 3);
      d      = $urandom_range(0, 15);
      p      = $urandom_range(1, 3);
      led_in = 4'($urandom_range(0, 15));
      settle_duty(($urandom() << 4) | 32'(d));
      wr_reg(2'd2, 32'(p));
      start_mode(32'(mode));
      for (int f = 0; f < 8; f++) begin
        case (mode)
          1:       exp_lit[f] = d;
          2:       exp_lit[f] = ((f / p) % 2 == 0) ? c_FRAME : 0;
          default: exp_lit[f] = breathe_level(d, f);
        endcase
      end
      check_frames($sformatf("random_it%0d_mode%0d_d%0d_p%0d", it, mode, d, p), 8, -1, 2'd0, 32'd0);
    end
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    rst    = 1'b1;
    WE     = 1'b0;
    Addr   = 2'd0;
    Din    = '0;
    led_in = 4'b1111;
    repeat (3) @(negedge clk);
    test_reset;
    test_direct;
    test_registers;
    test_pwm;
    test_duty_update;
    test_blink;
    test_breathe;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
